// File: rtl/huffman_decode.sv
// Captures canonical (codeword, symbol) pairs into a 16-entry table, then decodes a serial bitstream into symbols.
// Optional HUFF_DECODE_STATS_EN adds a saturating sym_count output.
module huffman_decode #(
   parameter int SYM_W  = 4,
   parameter int CODE_W = 16
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              EN,
   input  logic              clear,
   input  logic [CODE_W-1:0] tbl_code,
   input  logic [SYM_W-1:0]  tbl_sym,
   input  logic              tbl_valid,
   input  logic              tbl_done,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic              bit_ready,
   output logic [SYM_W-1:0]  sym_out,
   output logic              sym_valid,
   output logic              err
`ifdef HUFF_DECODE_STATS_EN
   ,
   output logic [15:0]       sym_count
`endif
);

   // state  | meaning
   // LOAD   | capturing table entries from the tree builder
   // DECODE | shifting stream bits into acc, matching against the table
   // ERROR  | empty table or over-long codeword; waits for Reset/clear
   typedef enum logic [1:0] {LOAD, DECODE, ERROR} state_t;

   localparam int DEPTH = 2**SYM_W;

   state_t              state;
   logic [CODE_W-1:0]   entry [DEPTH];
   logic [DEPTH-1:0]    ent_vld;
   logic [CODE_W-1:0]   acc;
   logic [CODE_W-1:0]   nxt;
   logic                hit;
   logic [SYM_W-1:0]    hit_sym;
   logic                code_legal;
   logic                any_valid;
   logic                flush;
   logic                tbl_wr;

   assign flush      = !Reset || (EN && clear);
   assign code_legal = tbl_code > CODE_W'(1);
   assign any_valid  = (|ent_vld) || (tbl_valid && code_legal);
   assign tbl_wr     = Reset && EN && !clear && (state == LOAD) && tbl_valid && code_legal;
   assign bit_ready  = (state == DECODE);

   // acc carries a leading sentinel 1, so nxt compares directly against sentinel-encoded entries
   always_comb begin
      nxt     = {acc[CODE_W-2:0], bit_in};
      hit     = 1'b0;
      hit_sym = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (ent_vld[i] && (entry[i] == nxt)) begin
            hit     = 1'b1;
            hit_sym = SYM_W'(i);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (tbl_wr) entry[tbl_sym] <= tbl_code;
   end

   always_ff @(posedge CLK) begin
      if (flush) begin
         state     <= LOAD;
         ent_vld   <= '0;
         acc       <= CODE_W'(1);
         sym_out   <= '0;
         sym_valid <= 1'b0;
         err       <= 1'b0;
`ifdef HUFF_DECODE_STATS_EN
         sym_count <= '0;
`endif
      end else if (!EN) begin
         sym_valid <= 1'b0;
      end else begin
         sym_valid <= 1'b0;
         case (state)
            LOAD: begin
               if (tbl_wr) ent_vld[tbl_sym] <= 1'b1;
               if (tbl_done) begin
                  if (any_valid) begin
                     state <= DECODE;
                  end else begin
                     state <= ERROR;
                     err   <= 1'b1;
                  end
               end
            end
            DECODE: begin
               if (bit_valid) begin
                  if (hit) begin
                     acc       <= CODE_W'(1);
                     sym_out   <= hit_sym;
                     sym_valid <= 1'b1;
`ifdef HUFF_DECODE_STATS_EN
                     if (sym_count != 16'hFFFF) sym_count <= sym_count + 16'd1;
`endif
                  end else if (nxt[CODE_W-1]) begin
                     state <= ERROR;
                     err   <= 1'b1;
                  end else begin
                     acc <= nxt;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_huffman_decode.sv
// Bench for huffman_decode: directed scenarios plus randomized traffic, checked every cycle against a bit-string model.
module tb_huffman_decode;

   logic        CLK = 1'b0;
   logic        Reset, EN, clear, tbl_valid, tbl_done, bit_in, bit_valid;
   logic [15:0] tbl_code;
   logic [3:0]  tbl_sym;
   logic        bit_ready, sym_valid, err;
   logic [3:0]  sym_out;
`ifdef HUFF_DECODE_STATS_EN
   logic [15:0] sym_count;
`endif

   huffman_decode dut (
      .CLK(CLK), .Reset(Reset), .EN(EN), .clear(clear),
      .tbl_code(tbl_code), .tbl_sym(tbl_sym), .tbl_valid(tbl_valid), .tbl_done(tbl_done),
      .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
      .sym_out(sym_out), .sym_valid(sym_valid), .err(err)
`ifdef HUFF_DECODE_STATS_EN
      , .sym_count(sym_count)
`endif
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // model: 0=LOAD 1=DECODE 2=ERROR; pending bits kept as an integer plus a bit count
   int          m_state;
   logic [15:0] m_code [16];
   bit          m_vld  [16];
   int          m_bits, m_n;
   int          m_sym_out;
   bit          m_sym_valid, m_err;
   int          m_count;
   int          obs[$];

   function automatic int clen(input logic [15:0] c);
      for (int i = 15; i >= 1; i--) if (c[i]) return i;
      return 0;
   endfunction

   task automatic m_flush();
      m_state = 0;
      foreach (m_vld[i]) m_vld[i] = 0;
      m_bits = 0; m_n = 0;
      m_sym_out = 0; m_sym_valid = 0; m_err = 0; m_count = 0;
   endtask

   task automatic m_step();
      bit any;
      int found;
      if (!Reset) begin m_flush(); return; end
      if (!EN) begin m_sym_valid = 0; return; end
      if (clear) begin m_flush(); return; end
      m_sym_valid = 0;
      if (m_state == 0) begin
         if (tbl_valid && clen(tbl_code) >= 1) begin
            m_code[tbl_sym] = tbl_code;
            m_vld[tbl_sym]  = 1;
         end
         if (tbl_done) begin
            any = 0;
            foreach (m_vld[i]) if (m_vld[i]) any = 1;
            if (any) m_state = 1;
            else begin m_state = 2; m_err = 1; end
         end
      end else if (m_state == 1 && bit_valid) begin
         m_bits = m_bits * 2 + int'(bit_in);
         m_n++;
         found = -1;
         for (int s = 0; s < 16 && found < 0; s++)
            if (m_vld[s] && clen(m_code[s]) == m_n && (int'(m_code[s]) % (1 << m_n)) == m_bits)
               found = s;
         if (found >= 0) begin
            m_sym_out = found; m_sym_valid = 1;
            m_bits = 0; m_n = 0;
            if (m_count < 65535) m_count++;
         end else if (m_n >= 15) begin
            m_state = 2; m_err = 1;
         end
      end
   endtask

   task automatic cyc();
      m_step();
      @(posedge CLK);
      #1;
      chk("sym_valid", sym_valid, m_sym_valid);
      chk("sym_out",   sym_out,   m_sym_out);
      chk("err",       err,       m_err);
      chk("bit_ready", bit_ready, m_state == 1);
`ifdef HUFF_DECODE_STATS_EN
      chk("sym_count", sym_count, m_count);
`endif
      if (sym_valid) obs.push_back(int'(sym_out));
   endtask

   task automatic drive(input logic rst, input logic en, input logic clr, input logic tv,
                        input logic [15:0] tc, input logic [3:0] ts, input logic td,
                        input logic bv, input logic bi);
      Reset = rst; EN = en; clear = clr; tbl_valid = tv; tbl_code = tc; tbl_sym = ts;
      tbl_done = td; bit_valid = bv; bit_in = bi;
      cyc();
   endtask

   task automatic idle();                 drive(1,1,0,0,16'h0,4'h0,0,0,0); endtask
   task automatic do_reset();             drive(0,1,0,0,16'h0,4'h0,0,0,0); endtask
   task automatic do_clear();             drive(1,1,1,0,16'h0,4'h0,0,0,0); endtask
   task automatic ld(input logic [3:0] s, input logic [15:0] c, input logic d);
      drive(1,1,0,1,c,s,d,0,0);
   endtask
   task automatic done();                 drive(1,1,0,0,16'h0,4'h0,1,0,0); endtask
   task automatic bt(input logic b);      drive(1,1,0,0,16'h0,4'h0,0,1,b); endtask

   task automatic load_std();
      ld(4'd3, 16'h0002, 0); ld(4'd5, 16'h0006, 0); ld(4'd9, 16'h0007, 0); done();
   endtask

   task automatic chk_obs(input string tag, input int a, input int b, input int c);
      chk({tag, "_n"}, obs.size(), 3);
      if (obs.size() == 3) begin
         chk({tag, "_s0"}, obs[0], a);
         chk({tag, "_s1"}, obs[1], b);
         chk({tag, "_s2"}, obs[2], c);
      end
   endtask

   initial begin
      drive(0,1,0,0,16'h0,4'h0,0,0,0);
      do_reset();
      chk("rst_sym_out", sym_out, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", bit_ready, 0);

      // basic decode
      load_std();
      obs.delete();
      bt(0); bt(1); bt(0); bt(1); bt(1); idle();
      chk_obs("t1", 3, 5, 9);

      // gapped bits with EN low
      do_clear(); load_std(); obs.delete();
      bt(0); idle(); bt(1);
      repeat (3) drive(1,0,0,0,16'h0,4'h0,0,1,1);
      bt(0); idle(); idle(); bt(1); idle(); bt(1); idle();
      chk_obs("t2", 3, 5, 9);

      // over-long codeword
      do_clear(); ld(4'd3, 16'h0002, 1); obs.delete();
      repeat (15) bt(1);
      chk("t3_err", err, 1);
      chk("t3_ready", bit_ready, 0);
      repeat (4) bt(0);
      chk("t3_nosym", obs.size(), 0);
      do_clear();
      chk("t3_clr_err", err, 0);

      // empty table, then write together with done
      done();
      chk("t4_err", err, 1);
      do_clear(); ld(4'd7, 16'h0002, 1); obs.delete();
      bt(0); idle();
      chk("t4_n", obs.size(), 1);
      if (obs.size() == 1) chk("t4_sym", obs[0], 7);

      // reset mid-codeword
      do_clear(); load_std(); bt(1); do_reset();
      chk("t5_ready", bit_ready, 0);
      ld(4'd5, 16'h0006, 1); obs.delete();
      bt(1); bt(0); idle();
      chk("t5_n", obs.size(), 1);
      if (obs.size() == 1) chk("t5_sym", obs[0], 5);

`ifdef HUFF_DECODE_STATS_EN
      do_clear(); load_std();
      repeat (5) bt(0);
      chk("st_count", sym_count, 5);
      do_clear();
      chk("st_clr", sym_count, 0);
`endif

      // randomized traffic
      for (int r = 0; r < 60; r++) begin
         if ($urandom_range(0, 9) == 0) do_reset(); else do_clear();
         for (int k = $urandom_range(0, 6); k > 0; k--) begin
            int len;
            logic [15:0] c;
            len = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(1, 5);
            c = 16'(1 << len) | 16'($urandom_range(0, (1 << len) - 1));
            if ($urandom_range(0, 9) == 0) c = 16'($urandom_range(0, 1));
            drive(1, ($urandom_range(0, 9) != 0), 0, 1, c, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom_range(0, 1));
         end
         done();
         for (int t = 0; t < 50; t++)
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 99) == 0), $urandom_range(0, 1), 16'($urandom),
                  4'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
